alu_out_buffer: RTL and testbench

ALU_OUT_BUFFER -- requirements
Module: alu_out_buffer

---
 rtl/alu_out_buffer.sv | 92 +++++++++
 tb/tb_alu_out_buffer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_out_buffer.sv
// Result FIFO between an ALU and its consumer, with flush and an occupancy count.
// Optional macro ALU_OUT_BUFFER_BYPASS_EN adds a same-cycle path from input to output when empty.
module alu_out_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    input  logic                       out_ready,
    output logic                       out_zero,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count_q;
    logic                  empty;
    logic                  bypass;
    logic                  push;
    logic                  pop;
    logic                  push_store;
    logic                  pop_store;

    assign empty = (count_q == '0);

`ifdef ALU_OUT_BUFFER_BYPASS_EN
    // Reset is included so outputs stay quiet while rst is held, whatever in_valid does.
    assign bypass = empty && !flush && in_valid && !rst;
`else
    assign bypass = 1'b0;
`endif

    assign in_ready  = (count_q < FULL);
    assign out_valid = !empty || bypass;
    assign count     = count_q;

    always_comb begin
        out_data = '0;
        if (!empty)
            out_data = mem[rd_ptr];
        else if (bypass)
            out_data = in_data;
    end

    assign out_zero = out_valid && (out_data == '0);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // A bypassed result taken by the consumer never touches storage.
    assign push_store = push && !(bypass && out_ready);
    assign pop_store  = pop && !empty;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_store)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_store)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_store, pop_store})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the count gates every read, so stale words never escape.
    always_ff @(posedge clk) begin
        if (push_store && !flush)
            mem[wr_ptr] <= in_data;
    end
endmodule

// File: tb/tb_alu_out_buffer.sv
// Directed, table-driven bench for alu_out_buffer (DEPTH=4, DATA_WIDTH=32).
module tb_alu_out_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        out_zero;
    logic [2:0]  count;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_out_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .out_zero(out_zero), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic [2:0]  e_cnt;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_ir;
        logic        e_oz;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [2:0] c, input logic ov,
                               input logic [31:0] od, input logic ir, input logic oz);
        check({name, ".count"}, 32'(count), 32'(c));
        check({name, ".out_valid"}, 32'(out_valid), 32'(ov));
        check({name, ".out_data"}, out_data, od);
        check({name, ".in_ready"}, 32'(in_ready), 32'(ir));
        check({name, ".out_zero"}, 32'(out_zero), 32'(oz));
    endtask

    task automatic idle();
        flush = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    endtask

    // Apply one cycle of inputs, then return inputs to idle and let outputs settle.
    task automatic step(input logic f, input logic iv, input logic [31:0] d, input logic ordy);
        flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 32'h11, 1'b0, 3'd1, 1'b1, 32'h11, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 32'h22, 1'b0, 3'd2, 1'b1, 32'h11, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 32'h33, 1'b0, 3'd3, 1'b1, 32'h11, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 32'h44, 1'b0, 3'd4, 1'b1, 32'h11, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 32'h55, 1'b0, 3'd4, 1'b1, 32'h11, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 32'h66, 1'b1, 3'd3, 1'b1, 32'h22, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 32'h00, 1'b1, 3'd2, 1'b1, 32'h33, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 32'h00, 1'b1, 3'd1, 1'b1, 32'h44, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 3'd0, 1'b0, 32'h00, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 32'h00, 1'b1, 3'd0, 1'b0, 32'h00, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 32'h00, 1'b0, 3'd1, 1'b1, 32'h00, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 32'h05, 1'b0, 3'd2, 1'b1, 32'h00, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 32'h00, 1'b1, 3'd1, 1'b1, 32'h05, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 32'h00, 1'b1, 3'd0, 1'b0, 32'h00, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 32'hA0, 1'b0, 3'd1, 1'b1, 32'hA0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 32'hA1, 1'b0, 3'd2, 1'b1, 32'hA0, 1'b1, 1'b0};

        idle();
        rst = 1'b1;
        #1;
        check_state("reset", 3'd0, 1'b0, 32'h0, 1'b1, 1'b0);
        #16;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].flush, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            check_state($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_ov,
                        tbl[i].e_od, tbl[i].e_ir, tbl[i].e_oz);
        end

        // Steady push+pop at count 2, wrapping both pointers three times.
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b1, 32'hA2 + 32'(k), 1'b1);
            check($sformatf("wrap%0d.count", k), 32'(count), 32'd2);
            check($sformatf("wrap%0d.out_data", k), out_data, 32'hA1 + 32'(k));
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_state("wrap_drain1", 3'd1, 1'b1, 32'hAD, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_state("wrap_drain2", 3'd0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with a simultaneous push and pop request.
        step(1'b0, 1'b1, 32'hB1, 1'b0);
        step(1'b0, 1'b1, 32'hB2, 1'b0);
        step(1'b0, 1'b1, 32'hB3, 1'b0);
        check("pre_flush.count", 32'(count), 32'd3);
        step(1'b1, 1'b1, 32'hB4, 1'b1);
        check_state("flush", 3'd0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'hC1, 1'b0);
        check_state("post_flush", 3'd1, 1'b1, 32'hC1, 1'b1, 1'b0);

        // Asynchronous reset mid-stream, sampled before any clock edge.
        step(1'b0, 1'b1, 32'hC2, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_state("async_rst", 3'd0, 1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1, 32'hD1, 1'b0);
        check_state("post_rst", 3'd1, 1'b1, 32'hD1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("post_rst_empty.count", 32'(count), 32'd0);

        // Empty buffer presented with a result and a ready consumer.
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'hABCD; out_ready = 1'b1;
        #1;
`ifdef ALU_OUT_BUFFER_BYPASS_EN
        check("bypass_same.out_valid", 32'(out_valid), 32'd1);
        check("bypass_same.out_data", out_data, 32'hABCD);
`else
        check("nobypass_same.out_valid", 32'(out_valid), 32'd0);
        check("nobypass_same.out_data", out_data, 32'h0);
`endif
        @(posedge clk);
        #1;
        idle();
        #1;
`ifdef ALU_OUT_BUFFER_BYPASS_EN
        check_state("bypass_next", 3'd0, 1'b0, 32'h0, 1'b1, 1'b0);
`else
        check_state("nobypass_next", 3'd1, 1'b1, 32'hABCD, 1'b1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
